// File: rtl/wb_pkg.sv
// Shared widths and the result record used by the writeback arbiter and its buffer.
package wb_pkg;

    localparam int AW   = 6;
    localparam int DW   = 32;
    localparam int NREG = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Result-source handshakes, the two register-file write ports and the hazard mask.
interface wb_arbiter_if;
    import wb_pkg::*;

    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;

    logic          fpu_valid;
    logic          fpu_ready;
    logic [AW-1:0] fpu_addr;
    logic [DW-1:0] fpu_data;

    logic          lsu_valid;
    logic          lsu_ready;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_data;

    logic          we1;
    logic [AW-1:0] aw1;
    logic [DW-1:0] wd1;
    logic          we2;
    logic [AW-1:0] aw2;
    logic [DW-1:0] wd2;

    logic [NREG-1:0] pend_mask;
    logic            idle;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output fpu_valid, fpu_addr, fpu_data,
        output lsu_valid, lsu_addr, lsu_data,
        input  fpu_ready, lsu_ready,
        input  we1, aw1, wd1, we2, aw2, wd2,
        input  pend_mask, idle
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  fpu_valid, fpu_addr, fpu_data,
        input  lsu_valid, lsu_addr, lsu_data,
        output fpu_ready, lsu_ready,
        output we1, aw1, wd1, we2, aw2, wd2,
        output pend_mask, idle
    );

endinterface

// File: rtl/wb_queue.sv
// Compacting result buffer: oldest entry sits at index 0, pops 0-2 from the head
// and appends 0-3 at the tail each cycle.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [1:0]      pop_cnt,
    input  logic [1:0]      push_cnt,
    input  wb_req_t         push_req [3],
    output logic [CW-1:0]   count,
    output wb_req_t         head0,
    output wb_req_t         head1,
    output logic [NREG-1:0] pend_mask
);

    localparam int IW = $clog2(DEPTH);

    wb_req_t          entry     [DEPTH];
    wb_req_t          nxt_entry [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] nxt_valid;

    // Valid bits are always a contiguous run from index 0, so a popcount is the occupancy.
    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CW'(valid[i]);
        end
    end

    assign head0 = entry[0];
    assign head1 = entry[1];

    always_comb begin
        int rem;
        int src;
        int k;
        rem = int'(count) - int'(pop_cnt);
        for (int i = 0; i < DEPTH; i++) begin
            nxt_entry[i] = '0;
            nxt_valid[i] = 1'b0;
            src = i + int'(pop_cnt);
            k   = i - rem;
            if (i < rem && src < DEPTH) begin
                nxt_entry[i] = entry[IW'(src)];
                nxt_valid[i] = 1'b1;
            end else if (k >= 0 && k < int'(push_cnt)) begin
                nxt_entry[i] = push_req[2'(k)];
                nxt_valid[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else begin
            valid <= nxt_valid;
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= nxt_entry[i];
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                pend_mask[entry[i].addr] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU/FPU/LSU results behind buffered ones and retires up
// to two per cycle while keeping writes to the same register in order.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    wb_arbiter_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] count;
    logic [CW-1:0] free;
    wb_req_t       head0;
    wb_req_t       head1;

    wb_req_t       raw [3];
    logic [2:0]    take;
    wb_req_t       arr [3];
    logic [1:0]    n_arr;

    wb_req_t       head;
    wb_req_t       second;
    logic          have_head;
    logic          have_second;
    logic          issue2;

    logic [1:0]    issued;
    logic [1:0]    pop_cnt;
    logic [1:0]    consumed;
    logic [1:0]    push_cnt;
    wb_req_t       push_req [3];

    logic          fpu_ready;
    logic          lsu_ready;

    // Thresholds guarantee the buffer cannot overflow since at least one entry retires per cycle.
    assign free      = CW'(DEPTH) - count;
    assign fpu_ready = rstn & (free >= CW'(2));
    assign lsu_ready = rstn & (free >= CW'(3));

    assign raw[0] = '{addr: bus.alu_addr, data: bus.alu_data};
    assign raw[1] = '{addr: bus.fpu_addr, data: bus.fpu_data};
    assign raw[2] = '{addr: bus.lsu_addr, data: bus.lsu_data};

    assign take[0] = rstn & bus.alu_valid & (bus.alu_addr != '0);
    assign take[1] = rstn & bus.fpu_valid & fpu_ready & (bus.fpu_addr != '0);
    assign take[2] = rstn & bus.lsu_valid & lsu_ready & (bus.lsu_addr != '0);

    always_comb begin
        int n;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            arr[i] = '0;
        end
        for (int i = 0; i < 3; i++) begin
            if (take[i]) begin
                arr[2'(n)] = raw[i];
                n = n + 1;
            end
        end
        n_arr = 2'(n);
    end

    // The first two entries of the logical queue: buffered ones first, then arrivals.
    always_comb begin
        head        = arr[0];
        second      = arr[1];
        have_head   = (n_arr != 2'd0);
        have_second = (n_arr >= 2'd2);
        if (count >= CW'(2)) begin
            head        = head0;
            second      = head1;
            have_head   = 1'b1;
            have_second = 1'b1;
        end else if (count == CW'(1)) begin
            head        = head0;
            second      = arr[0];
            have_head   = 1'b1;
            have_second = (n_arr != 2'd0);
        end
    end

    assign issue2   = have_head & have_second & (second.addr != head.addr);
    assign issued   = {1'b0, have_head} + {1'b0, issue2};
    assign pop_cnt  = (count >= CW'(issued)) ? issued : count[1:0];
    assign consumed = issued - pop_cnt;
    assign push_cnt = n_arr - consumed;

    always_comb begin
        int idx;
        for (int k = 0; k < 3; k++) begin
            idx         = k + int'(consumed);
            push_req[k] = '0;
            if (idx < 3) begin
                push_req[k] = arr[2'(idx)];
            end
        end
    end

    wb_queue #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_queue (
        .clk       (clk),
        .rstn      (rstn),
        .pop_cnt   (pop_cnt),
        .push_cnt  (push_cnt),
        .push_req  (push_req),
        .count     (count),
        .head0     (head0),
        .head1     (head1),
        .pend_mask (bus.pend_mask)
    );

    assign bus.fpu_ready = fpu_ready;
    assign bus.lsu_ready = lsu_ready;

    assign bus.we1 = have_head;
    assign bus.aw1 = have_head ? head.addr : '0;
    assign bus.wd1 = have_head ? head.data : '0;
    assign bus.we2 = issue2;
    assign bus.aw2 = issue2 ? second.addr : '0;
    assign bus.wd2 = issue2 ? second.data : '0;

    assign bus.idle = (count == '0);

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that sits directly upstream of the 64-entry, dual-write-port register file. It collects results from the ALU, FPU and load/store unit, keeps per-register write order through a small result buffer, and drives both register-file write ports. Up to two writes retire per cycle. It also exports a pending-write mask to the issue stage for hazard checks.

## Interface
- `DEPTH`, 4: result-buffer entries; power of two, ≥4.
- `AW`, 6: register address width (64 registers).
- `DW`, 32: data width.

- `clk`  in  1  clock.
- `rstn`  in  1  asynchronous active-low reset.
- `alu_valid`  in  1  ALU result valid; always accepted, no ready.
- `alu_addr`, `alu_data`  in  AW / DW  ALU destination and value.
- `fpu_valid`  in  1  FPU result valid.
- `fpu_ready`  out  1  FPU result accepted when `fpu_valid & fpu_ready`.
- `fpu_addr`, `fpu_data`  in  AW / DW  FPU destination and value.
- `lsu_valid`  in  1  LSU result valid.
- `lsu_ready`  out  1  LSU handshake ready.
- `lsu_addr`, `lsu_data`  in  AW / DW  LSU destination and value.
- `we1`, `aw1`, `wd1`  out  1 / AW / DW  regfile write port 1.
- `we2`, `aw2`, `wd2`  out  1 / AW / DW  regfile write port 2.
- `pend_mask`  out  64  bit n set ⇔ a buffered (not yet written) entry targets register n.
- `idle`  out  1  buffer empty.

## Operation
- Logical queue each cycle = buffer entries (oldest first), then the accepted arrivals in the fixed order ALU, FPU, LSU.
- An arrival with address 0 is accepted (handshake completes) and then discarded. It is never written and never buffered.
- Head entry of the queue, if present, always issues on port 1.
- Second entry issues on port 2 only if its address ≠ head address. Otherwise only one write issues, which preserves same-register order. Entries beyond the second never issue.
- Issued entries leave the queue. Remaining arrivals are appended to the buffer tail in queue order.
- Zero-latency bypass: with an empty buffer, arrivals drive the write ports in the same cycle.
- Ready rule, from the registered free count `free = DEPTH − occupancy`:
  - `fpu_ready = (free ≥ 2)`.
  - `lsu_ready = (free ≥ 3)`.
  - Both are independent of the valids.
  - Because at least one entry retires whenever the queue is non-empty, the buffer never overflows and an ALU result is never lost, even at `free = 0`.
- Idle port: when `weN = 0`, `awN` and `wdN` are driven to 0.
- `pend_mask` is decoded from valid buffer entries only; arrivals are excluded. The issue stage covers in-flight bypass through the regfile's forwarding.

## Timing
- Result latency:
  - Empty buffer: written at the clock edge ending the arrival cycle.
  - Otherwise: written after all older entries, at a minimum of ⌈position/2⌉ cycles.
- Write ports, `fpu_ready`, `lsu_ready` and `idle` are combinational from buffer state and current arrivals. `pend_mask` is a decode of registered state.
- While `rstn` is low, all of the following are 0:
  - `we1`, `we2`, `aw1`, `aw2`, `wd1`, `wd2`.
  - `fpu_ready`, `lsu_ready`, `pend_mask`.
  - `idle` is 1.
  - Arrivals are ignored.
- Reset mid-operation: buffered results are discarded immediately, with no partial write. After release, `free = DEPTH`.
- Simultaneous same-address arrivals are ordered ALU before FPU before LSU. The regfile therefore ends with the LSU value after two or more cycles.

## Structure
- `wb_pkg`:
  - constants `AW`, `DW`.
  - `typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data;} wb_req_t`.
- Sub-module `wb_queue`:
  - shifting buffer of `DEPTH` `wb_req_t` entries plus a valid vector.
  - pop 0–2 from the head and append 0–3 at the tail in one cycle.
  - outputs occupancy and `pend_mask`.
- `wb_arbiter` contains candidate selection, the address-0 filter, ready generation and port muxing.

## Test plan
- ALU only: addr 5, data 0x12345678, buffer empty → same cycle `we1=1`, `aw1=5`, `wd1=0x12345678`, `we2=0`, `pend_mask=0`.
- ALU/FPU/LSU together: addrs 3/4/5 → port1 writes 3, port2 writes 4, `pend_mask[5]=1`. Next cycle port1 writes 5, then `idle=1`.
- ALU addr 7 data 1 and FPU addr 7 data 2 together → cycle t: single write (7, 1). Cycle t+1: write (7, 2). Regfile reads 2.
- LSU addr 0 data 0xFFFFFFFF with `lsu_ready=1` → handshake completes, `we1=we2=0`, buffer unchanged.
- All three sources valid every cycle, all addr 9, for 10 cycles:
  - `lsu_ready` drops when `free < 3` and `fpu_ready` when `free < 2`.
  - Occupancy never exceeds `DEPTH`.
  - Every accepted value is written in ALU, FPU, LSU order.
- Reset with 3 entries buffered → all write outputs and `pend_mask` go to 0 asynchronously. After release, `idle=1` and both readies are 1.
